// File: rtl/mc_sequencer.sv
// mc_sequencer: multicycle control sequencer for the MIPS-subset core, driven by a pre-decoded class.
// Optional feature macro MC_SEQ_PERF_EN adds the cyc_cnt/ret_cnt performance counters.
module mc_sequencer #(
    parameter int MEM_WAIT   = 1,
    parameter int SHIFT_LAT  = 2,
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        reset_in,
    input  logic [3:0]  iclass,
    input  logic        overflow,
    input  logic        branch_taken,
    input  logic        div_zero,
    input  logic        md_done,
    output logic        reset_out,
    output logic        pc_w,
    output logic        ir_w,
    output logic        ab_w,
    output logic        aluout_w,
    output logic        mdr_w,
    output logic        rb_w,
    output logic        hilo_w,
    output logic        epc_w,
    output logic        mem_w,
    output logic        mem_addr_sel,
    output logic [2:0]  pc_src,
    output logic        md_start,
    output logic [1:0]  exc_code,
    output logic [3:0]  state,
    output logic        halted,
    output logic [31:0] cyc_cnt,
    output logic [31:0] ret_cnt
);

    typedef enum logic [3:0] {
        S_RESET      = 4'd0,
        S_FETCH      = 4'd1,
        S_FETCH_WAIT = 4'd2,
        S_IR_LOAD    = 4'd3,
        S_DECODE     = 4'd4,
        S_EXEC       = 4'd5,
        S_MEM        = 4'd6,
        S_MEM_WAIT   = 4'd7,
        S_MDR        = 4'd8,
        S_WB         = 4'd9,
        S_MD_WAIT    = 4'd10,
        S_HILO       = 4'd11,
        S_EXC        = 4'd12,
        S_EXC_VEC    = 4'd13,
        S_HALT       = 4'd14
    } state_t;

    localparam logic [3:0] C_ALU_R   = 4'd0;
    localparam logic [3:0] C_ALU_I   = 4'd1;
    localparam logic [3:0] C_SHIFT   = 4'd2;
    localparam logic [3:0] C_LOAD    = 4'd3;
    localparam logic [3:0] C_STORE   = 4'd4;
    localparam logic [3:0] C_BRANCH  = 4'd5;
    localparam logic [3:0] C_JUMP    = 4'd6;
    localparam logic [3:0] C_JAL     = 4'd7;
    localparam logic [3:0] C_JR      = 4'd8;
    localparam logic [3:0] C_MULTDIV = 4'd9;
    localparam logic [3:0] C_MFHILO  = 4'd10;
    localparam logic [3:0] C_RTE     = 4'd11;
    localparam logic [3:0] C_BREAK   = 4'd12;

    localparam logic [2:0] PC_ALU    = 3'd0;
    localparam logic [2:0] PC_ALUOUT = 3'd1;
    localparam logic [2:0] PC_JUMP   = 3'd2;
    localparam logic [2:0] PC_EPC    = 3'd3;
    localparam logic [2:0] PC_VEC    = 3'd4;
    localparam logic [2:0] PC_A      = 3'd5;

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] MEM_WAIT_C   = CNT_W'(MEM_WAIT);
    localparam logic [CNT_W-1:0] SHIFT_LAT_C  = CNT_W'(SHIFT_LAT);
    localparam logic [CNT_W-1:0] MD_TIMEOUT_C = CNT_W'(MD_TIMEOUT);

    typedef struct packed {
        logic       pc_w;
        logic       ir_w;
        logic       ab_w;
        logic       aluout_w;
        logic       mdr_w;
        logic       rb_w;
        logic       hilo_w;
        logic       epc_w;
        logic       mem_w;
        logic       mem_addr_sel;
        logic [2:0] pc_src;
        logic       md_start;
        logic       halted;
    } ctl_t;

    state_t           cur, nxt;
    logic [CNT_W-1:0] cnt, cnt_inc, cnt_nxt;
    logic [1:0]       exc_nxt;
    logic             reset_out_nxt;
    logic             counting;
    ctl_t             ctl, ctl_nxt;

    // Next-state selection; every parameterised wait exits when the incremented count equals its parameter.
    always_comb begin
        nxt     = cur;
        exc_nxt = exc_code;
        cnt_inc = cnt + CNT_ONE;
        case (cur)
            S_RESET:      nxt = S_FETCH;
            S_FETCH:      nxt = (MEM_WAIT == 0) ? S_IR_LOAD : S_FETCH_WAIT;
            S_FETCH_WAIT: if (cnt_inc == MEM_WAIT_C) nxt = S_IR_LOAD;
            S_IR_LOAD:    nxt = S_DECODE;
            S_DECODE:     nxt = S_EXEC;
            S_EXEC: begin
                case (iclass)
                    C_ALU_R, C_ALU_I: begin
                        if (overflow) begin
                            nxt     = S_EXC;
                            exc_nxt = 2'd1;
                        end else begin
                            nxt = S_WB;
                        end
                    end
                    C_SHIFT:  if (cnt_inc == SHIFT_LAT_C) nxt = S_WB;
                    C_LOAD, C_STORE: nxt = S_MEM;
                    C_BRANCH, C_JUMP, C_JAL, C_JR, C_RTE: nxt = S_FETCH;
                    C_MULTDIV: begin
                        if (div_zero) begin
                            nxt     = S_EXC;
                            exc_nxt = 2'd2;
                        end else begin
                            nxt = S_MD_WAIT;
                        end
                    end
                    C_MFHILO: nxt = S_WB;
                    C_BREAK:  nxt = S_HALT;
                    default: begin
                        nxt     = S_EXC;
                        exc_nxt = 2'd0;
                    end
                endcase
            end
            S_MEM: begin
                if (iclass == C_STORE)
                    nxt = S_FETCH;
                else
                    nxt = (MEM_WAIT == 0) ? S_MDR : S_MEM_WAIT;
            end
            S_MEM_WAIT: if (cnt_inc == MEM_WAIT_C) nxt = S_MDR;
            S_MDR:      nxt = S_WB;
            S_WB:       nxt = S_FETCH;
            S_MD_WAIT: begin
                if (md_done) begin
                    nxt = S_HILO;
                end else if (cnt_inc == MD_TIMEOUT_C) begin
                    nxt     = S_EXC;
                    exc_nxt = 2'd3;
                end
            end
            S_HILO:     nxt = S_FETCH;
            S_EXC:      nxt = S_EXC_VEC;
            S_EXC_VEC:  nxt = S_FETCH;
            S_HALT:     nxt = S_HALT;
            default:    nxt = S_RESET;
        endcase

        counting = (nxt == cur) &&
                   (cur == S_FETCH_WAIT || cur == S_EXEC || cur == S_MEM_WAIT || cur == S_MD_WAIT);
        cnt_nxt  = counting ? cnt_inc : '0;
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        ctl_nxt       = '0;
        reset_out_nxt = (nxt == S_RESET);
        case (nxt)
            S_IR_LOAD: begin
                ctl_nxt.ir_w   = 1'b1;
                ctl_nxt.pc_w   = 1'b1;
                ctl_nxt.pc_src = PC_ALU;
            end
            S_DECODE: ctl_nxt.ab_w = 1'b1;
            S_EXEC: begin
                case (iclass)
                    C_ALU_R, C_ALU_I, C_LOAD, C_STORE: ctl_nxt.aluout_w = 1'b1;
                    C_SHIFT: ctl_nxt.aluout_w = ((cnt_nxt + CNT_ONE) == SHIFT_LAT_C);
                    C_BRANCH: begin
                        ctl_nxt.pc_src = PC_ALUOUT;
                        ctl_nxt.pc_w   = branch_taken;
                    end
                    C_JUMP: begin
                        ctl_nxt.pc_w   = 1'b1;
                        ctl_nxt.pc_src = PC_JUMP;
                    end
                    C_JAL: begin
                        ctl_nxt.pc_w   = 1'b1;
                        ctl_nxt.pc_src = PC_JUMP;
                        ctl_nxt.rb_w   = 1'b1;
                    end
                    C_JR: begin
                        ctl_nxt.pc_w   = 1'b1;
                        ctl_nxt.pc_src = PC_A;
                    end
                    C_RTE: begin
                        ctl_nxt.pc_w   = 1'b1;
                        ctl_nxt.pc_src = PC_EPC;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                ctl_nxt.mem_addr_sel = 1'b1;
                ctl_nxt.mem_w        = (iclass == C_STORE);
            end
            S_MEM_WAIT: ctl_nxt.mem_addr_sel = 1'b1;
            S_MDR:      ctl_nxt.mdr_w = 1'b1;
            S_WB:       ctl_nxt.rb_w = 1'b1;
            S_MD_WAIT:  ctl_nxt.md_start = (cur == S_EXEC);
            S_HILO:     ctl_nxt.hilo_w = 1'b1;
            S_EXC:      ctl_nxt.epc_w = 1'b1;
            S_EXC_VEC: begin
                ctl_nxt.pc_w   = 1'b1;
                ctl_nxt.pc_src = PC_VEC;
            end
            S_HALT:     ctl_nxt.halted = 1'b1;
            default: ;
        endcase
    end

    // State, counter and output registers; reset_in overrides everything.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            cur       <= S_RESET;
            cnt       <= '0;
            ctl       <= '0;
            reset_out <= 1'b1;
            exc_code  <= 2'd0;
        end else begin
            cur       <= nxt;
            cnt       <= cnt_nxt;
            ctl       <= ctl_nxt;
            reset_out <= reset_out_nxt;
            exc_code  <= exc_nxt;
        end
    end

    assign state        = cur;
    assign pc_w         = ctl.pc_w;
    assign ir_w         = ctl.ir_w;
    assign ab_w         = ctl.ab_w;
    assign aluout_w     = ctl.aluout_w;
    assign mdr_w        = ctl.mdr_w;
    assign rb_w         = ctl.rb_w;
    assign hilo_w       = ctl.hilo_w;
    assign epc_w        = ctl.epc_w;
    assign mem_w        = ctl.mem_w;
    assign mem_addr_sel = ctl.mem_addr_sel;
    assign pc_src       = ctl.pc_src;
    assign md_start     = ctl.md_start;
    assign halted       = ctl.halted;

`ifdef MC_SEQ_PERF_EN
    // Retirement is any return to FETCH except the post-reset and post-exception ones.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            if (cur != S_RESET && cur != S_HALT)
                cyc_cnt <= cyc_cnt + 32'd1;
            if (nxt == S_FETCH && cur != S_RESET && cur != S_EXC_VEC)
                ret_cnt <= ret_cnt + 32'd1;
        end
    end
`else
    assign cyc_cnt = '0;
    assign ret_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: a per-instruction cycle-list model feeds a compare queue.
// Honours MC_SEQ_PERF_EN for the performance-counter checks.
module tb_mc_sequencer;

    localparam int MEM_WAIT   = 1;
    localparam int SHIFT_LAT  = 2;
    localparam int MD_TIMEOUT = 40;
    localparam int CNT_W      = 6;
    localparam int HALT_CYCLES = 100;

    localparam logic [3:0] ALU_R = 4'd0, ALU_I = 4'd1, SHIFT = 4'd2, LOAD = 4'd3, STORE = 4'd4,
                           BRANCH = 4'd5, JUMP = 4'd6, JAL = 4'd7, JR = 4'd8, MULTDIV = 4'd9,
                           MFHILO = 4'd10, RTE = 4'd11, BREAK = 4'd12;

    logic        clk = 1'b0;
    logic        reset_in = 1'b1;
    logic [3:0]  iclass = 4'd0;
    logic        overflow = 1'b0;
    logic        branch_taken = 1'b0;
    logic        div_zero = 1'b0;
    logic        md_done = 1'b0;
    logic        reset_out, pc_w, ir_w, ab_w, aluout_w, mdr_w, rb_w, hilo_w, epc_w, mem_w, mem_addr_sel;
    logic [2:0]  pc_src;
    logic        md_start, halted;
    logic [1:0]  exc_code;
    logic [3:0]  state;
    logic [31:0] cyc_cnt, ret_cnt;

    typedef struct packed {
        logic       reset_out;
        logic       pc_w;
        logic       ir_w;
        logic       ab_w;
        logic       aluout_w;
        logic       mdr_w;
        logic       rb_w;
        logic       hilo_w;
        logic       epc_w;
        logic       mem_w;
        logic       mem_addr_sel;
        logic [2:0] pc_src;
        logic       md_start;
        logic [1:0] exc_code;
        logic       halted;
    } outv_t;

    outv_t      exp_q[$];
    outv_t      act, exp_v;
    logic [1:0] model_exc = 2'd0;
    int         md_idx;
    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc_idx = 0;
    int         len;

    mc_sequencer #(
        .MEM_WAIT(MEM_WAIT), .SHIFT_LAT(SHIFT_LAT), .MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_in(reset_in), .iclass(iclass), .overflow(overflow),
        .branch_taken(branch_taken), .div_zero(div_zero), .md_done(md_done),
        .reset_out(reset_out), .pc_w(pc_w), .ir_w(ir_w), .ab_w(ab_w), .aluout_w(aluout_w),
        .mdr_w(mdr_w), .rb_w(rb_w), .hilo_w(hilo_w), .epc_w(epc_w), .mem_w(mem_w),
        .mem_addr_sel(mem_addr_sel), .pc_src(pc_src), .md_start(md_start), .exc_code(exc_code),
        .state(state), .halted(halted), .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
    );

    always #5 clk = ~clk;

    assign act = {reset_out, pc_w, ir_w, ab_w, aluout_w, mdr_w, rb_w, hilo_w, epc_w, mem_w,
                  mem_addr_sel, pc_src, md_start, exc_code, halted};

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want)
            n_pass++;
        else
            $display("[TB] FAIL %s (cycle %0d): got %h expected %h", name, cyc_idx, got, want);
    endtask

    // Compare process: every queued expectation is checked on the falling edge of its cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            checkOutput("cycle", 32'(act), 32'(exp_v));
            cyc_idx++;
        end
    end

    task automatic pushV(input outv_t v);
        v.exc_code = model_exc;
        exp_q.push_back(v);
    endtask

    task automatic pushExc(input logic [1:0] code);
        outv_t v;
        model_exc = code;
        v = '0; v.epc_w = 1'b1; pushV(v);
        v = '0; v.pc_w = 1'b1; v.pc_src = 3'd4; pushV(v);
    endtask

    // Expected cycle list of one instruction, FETCH through its last cycle.
    task automatic buildInstr(input logic [3:0] cls, input logic ovf, input logic bt, input logic dz,
                              input int md_cycles);
        outv_t v;
        int base = exp_q.size();
        md_idx = -1;
        v = '0; pushV(v);
        for (int i = 0; i < MEM_WAIT; i++) begin v = '0; pushV(v); end
        v = '0; v.ir_w = 1'b1; v.pc_w = 1'b1; pushV(v);
        v = '0; v.ab_w = 1'b1; pushV(v);
        case (cls)
            ALU_R, ALU_I: begin
                v = '0; v.aluout_w = 1'b1; pushV(v);
                if (ovf) pushExc(2'd1);
                else begin v = '0; v.rb_w = 1'b1; pushV(v); end
            end
            SHIFT: begin
                for (int i = 0; i < SHIFT_LAT; i++) begin
                    v = '0; v.aluout_w = (i == SHIFT_LAT - 1); pushV(v);
                end
                v = '0; v.rb_w = 1'b1; pushV(v);
            end
            LOAD: begin
                v = '0; v.aluout_w = 1'b1; pushV(v);
                for (int i = 0; i < 1 + MEM_WAIT; i++) begin v = '0; v.mem_addr_sel = 1'b1; pushV(v); end
                v = '0; v.mdr_w = 1'b1; pushV(v);
                v = '0; v.rb_w = 1'b1; pushV(v);
            end
            STORE: begin
                v = '0; v.aluout_w = 1'b1; pushV(v);
                v = '0; v.mem_w = 1'b1; v.mem_addr_sel = 1'b1; pushV(v);
            end
            BRANCH: begin v = '0; v.pc_w = bt; v.pc_src = 3'd1; pushV(v); end
            JUMP:   begin v = '0; v.pc_w = 1'b1; v.pc_src = 3'd2; pushV(v); end
            JAL:    begin v = '0; v.pc_w = 1'b1; v.pc_src = 3'd2; v.rb_w = 1'b1; pushV(v); end
            JR:     begin v = '0; v.pc_w = 1'b1; v.pc_src = 3'd5; pushV(v); end
            RTE:    begin v = '0; v.pc_w = 1'b1; v.pc_src = 3'd3; pushV(v); end
            MULTDIV: begin
                v = '0; pushV(v);
                if (dz) pushExc(2'd2);
                else if (md_cycles > 0) begin
                    for (int i = 0; i < md_cycles; i++) begin v = '0; v.md_start = (i == 0); pushV(v); end
                    md_idx = exp_q.size() - 1 - base;
                    v = '0; v.hilo_w = 1'b1; pushV(v);
                end else begin
                    for (int i = 0; i < MD_TIMEOUT; i++) begin v = '0; v.md_start = (i == 0); pushV(v); end
                    pushExc(2'd3);
                end
            end
            MFHILO: begin
                v = '0; pushV(v);
                v = '0; v.rb_w = 1'b1; pushV(v);
            end
            BREAK: begin
                v = '0; pushV(v);
                for (int i = 0; i < HALT_CYCLES; i++) begin v = '0; v.halted = 1'b1; pushV(v); end
            end
            default: begin
                v = '0; pushV(v);
                pushExc(2'd0);
            end
        endcase
    endtask

    // Wait until the compare process has consumed the queue; md_done is raised in cycle md_idx.
    task automatic drain(input logic [3:0] cls, input logic ovf, input logic bt, input logic dz);
        for (int c = 0; ; c++) begin
            @(negedge clk); #1;
            if (c == 0) begin
                iclass = cls; overflow = ovf; branch_taken = bt; div_zero = dz;
            end
            md_done = (c == md_idx);
            if (exp_q.size() == 0) break;
            if (c >= 400) begin
                $display("[TB] FAIL drain_timeout: got %0d entries left expected 0", exp_q.size());
                n_checks++;
                exp_q.delete();
                break;
            end
        end
        md_done = 1'b0;
    endtask

    task automatic applyStimulus(input logic [3:0] cls, input logic ovf, input logic bt, input logic dz,
                                 input int md_cycles, input int keep, output int n);
        buildInstr(cls, ovf, bt, dz, md_cycles);
        n = exp_q.size();
        if (keep > 0)
            while (exp_q.size() > keep) void'(exp_q.pop_back());
        drain(cls, ovf, bt, dz);
    endtask

    task automatic applyReset(input int cycles);
        outv_t v;
        reset_in  = 1'b1;
        model_exc = 2'd0;
        for (int i = 0; i < cycles; i++) begin v = '0; v.reset_out = 1'b1; pushV(v); end
        md_idx = -1;
        drain(iclass, overflow, branch_taken, div_zero);
        checkOutput("reset_out_held", 32'(reset_out), 32'd1);
        reset_in = 1'b0;
    endtask

    initial begin
        @(negedge clk); #1;
        applyReset(3);

        applyStimulus(ALU_R, 1'b0, 1'b0, 1'b0, 0, 0, len);
        checkOutput("alu_r_len", 32'(len), 32'd6);
        applyStimulus(ALU_R, 1'b0, 1'b0, 1'b0, 0, 0, len);
        applyStimulus(ALU_R, 1'b0, 1'b0, 1'b0, 0, 0, len);
        applyStimulus(BREAK, 1'b0, 1'b0, 1'b0, 0, 0, len);
        checkOutput("halted_hold", 32'(halted), 32'd1);
`ifdef MC_SEQ_PERF_EN
        checkOutput("ret_cnt", ret_cnt, 32'd3);
        checkOutput("cyc_cnt", cyc_cnt, 32'd23);
`else
        checkOutput("ret_cnt_tied", ret_cnt, 32'd0);
        checkOutput("cyc_cnt_tied", cyc_cnt, 32'd0);
`endif
        applyReset(2);

        applyStimulus(LOAD, 1'b0, 1'b0, 1'b0, 0, 0, len);
        checkOutput("load_len", 32'(len), 32'd9);
        applyStimulus(STORE,  1'b0, 1'b0, 1'b0, 0, 0, len);
        applyStimulus(SHIFT,  1'b0, 1'b0, 1'b0, 0, 0, len);
        checkOutput("shift_len", 32'(len), 32'd7);
        applyStimulus(JUMP,   1'b0, 1'b0, 1'b0, 0, 0, len);
        applyStimulus(JAL,    1'b0, 1'b0, 1'b0, 0, 0, len);
        applyStimulus(JR,     1'b0, 1'b0, 1'b0, 0, 0, len);
        applyStimulus(RTE,    1'b0, 1'b0, 1'b0, 0, 0, len);
        applyStimulus(MFHILO, 1'b0, 1'b0, 1'b0, 0, 0, len);

        applyStimulus(MULTDIV, 1'b0, 1'b0, 1'b0, 10, 0, len);
        checkOutput("md_done_len", 32'(len), 32'd16);
        applyStimulus(MULTDIV, 1'b0, 1'b0, 1'b0, 0, 0, len);
        checkOutput("md_timeout_len", 32'(len), 32'd47);
        checkOutput("exc_code_timeout", 32'(exc_code), 32'd3);
        applyStimulus(MULTDIV, 1'b0, 1'b0, 1'b1, 0, 0, len);

        applyStimulus(ALU_I, 1'b1, 1'b0, 1'b0, 0, 0, len);
        checkOutput("exc_code_ovf", 32'(exc_code), 32'd1);
        applyStimulus(4'd14, 1'b0, 1'b0, 1'b0, 0, 0, len);
        checkOutput("exc_code_illegal", 32'(exc_code), 32'd0);
        applyStimulus(ALU_I, 1'b0, 1'b0, 1'b0, 0, 0, len);

        applyStimulus(BRANCH, 1'b0, 1'b0, 1'b0, 0, 0, len);
        applyStimulus(BRANCH, 1'b0, 1'b1, 1'b0, 0, 0, len);

        applyStimulus(MULTDIV, 1'b0, 1'b0, 1'b0, 20, 8, len);
        applyReset(2);
        applyStimulus(ALU_R, 1'b0, 1'b0, 1'b0, 0, 0, len);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
